// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states and default width.
package mdu_pkg;

    localparam int unsigned MDU_XLEN = 32;

    localparam logic [2:0] MDU_OP_MULT  = 3'd0;
    localparam logic [2:0] MDU_OP_MULTU = 3'd1;
    localparam logic [2:0] MDU_OP_DIV   = 3'd2;
    localparam logic [2:0] MDU_OP_DIVU  = 3'd3;
    localparam logic [2:0] MDU_OP_MTHI  = 3'd4;
    localparam logic [2:0] MDU_OP_MTLO  = 3'd5;
    localparam logic [2:0] MDU_OP_MADD  = 3'd6;
    localparam logic [2:0] MDU_OP_MSUB  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DIV_RUN = 2'd1,
        S_DIV_FIX = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mdu_div_core.sv
// Radix-2 restoring divider: latches magnitudes and result signs on start, then runs
// one shift-subtract step per cycle for XLEN cycles. Signed results are applied combinationally.
module mdu_div_core #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic            signed_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] quo_o,
    output logic [XLEN-1:0] rem_o,
    output logic            last_step_o
);

    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             active_q, active_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;

    logic             a_neg, b_neg;
    logic [XLEN-1:0]  a_abs, b_abs;
    logic [XLEN:0]    shifted, diff;

    assign a_neg = signed_i & dividend_i[XLEN-1];
    assign b_neg = signed_i & divisor_i[XLEN-1];
    assign a_abs = a_neg ? -dividend_i : dividend_i;
    assign b_abs = b_neg ? -divisor_i : divisor_i;

    assign shifted = {rem_q, quo_q[XLEN-1]};
    assign diff    = shifted - {1'b0, dvs_q};

    assign last_step_o = active_q && (cnt_q == CNT_W'(XLEN - 1));

    always_comb begin
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        if (start_i) begin
            quo_d    = a_abs;
            rem_d    = '0;
            dvs_d    = b_abs;
            cnt_d    = '0;
            active_d = 1'b1;
            // Zero divisor keeps an all-ones quotient unsigned; remainder restores src1.
            qneg_d   = (a_neg ^ b_neg) & (divisor_i != '0);
            rneg_d   = a_neg;
        end else if (abort_i) begin
            active_d = 1'b0;
        end else if (active_q) begin
            if (!diff[XLEN]) begin
                rem_d = diff[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b1};
            end else begin
                rem_d = shifted[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b0};
            end
            cnt_d = cnt_q + 1'b1;
            if (last_step_o) begin
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
        end else begin
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
        end
    end

    assign quo_o = qneg_q ? -quo_q : quo_q;
    assign rem_o = rneg_q ? -rem_q : rem_q;

endmodule

// File: rtl/iter_muldiv_hilo.sv
// HI/LO multiply/divide unit: single-cycle multiply and MT ops, iterative divide.
// Define MDU_MADD_EN to enable the MADD/MSUB accumulate ops (otherwise they are no-ops).
module iter_muldiv_hilo
    import mdu_pkg::*;
#(
    parameter int unsigned XLEN  = MDU_XLEN,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_src1,
    input  logic [XLEN-1:0] req_src2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    mdu_state_e        state_q, state_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              done_q, done_d;

    logic              accept;
    logic              div_start, div_abort, div_last;
    logic [XLEN-1:0]   div_quo, div_rem;
    logic              mul_signed, sa, sb;
    logic [2*XLEN-1:0] prod;

    assign req_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign accept    = req_valid & req_ready & ~flush;
    assign div_abort = flush & busy;

    // Sign-extending to 2*XLEN and truncating gives the low 2*XLEN bits of the signed product.
    assign mul_signed = (req_op != MDU_OP_MULTU);
    assign sa         = mul_signed & req_src1[XLEN-1];
    assign sb         = mul_signed & req_src2[XLEN-1];
    assign prod       = {{XLEN{sa}}, req_src1} * {{XLEN{sb}}, req_src2};

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        div_start = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (req_op)
                        MDU_OP_MULT, MDU_OP_MULTU: {hi_d, lo_d} = prod;
                        MDU_OP_DIV, MDU_OP_DIVU: begin
                            div_start = 1'b1;
                            state_d   = S_DIV_RUN;
                        end
                        MDU_OP_MTHI: hi_d = req_src1;
                        MDU_OP_MTLO: lo_d = req_src1;
`ifdef MDU_MADD_EN
                        MDU_OP_MADD: {hi_d, lo_d} = {hi_q, lo_q} + prod;
                        MDU_OP_MSUB: {hi_d, lo_d} = {hi_q, lo_q} - prod;
`endif
                        default: ;
                    endcase
                end
            end
            S_DIV_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (div_last) begin
                    state_d = S_DIV_FIX;
                end
            end
            S_DIV_FIX: begin
                state_d = S_IDLE;
                if (!flush) begin
                    lo_d   = div_quo;
                    hi_d   = div_rem;
                    done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    mdu_div_core #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_div_core (
        .clk         (clk),
        .reset       (reset),
        .start_i     (div_start),
        .abort_i     (div_abort),
        .signed_i    (req_op == MDU_OP_DIV),
        .dividend_i  (req_src1),
        .divisor_i   (req_src2),
        .quo_o       (div_quo),
        .rem_o       (div_rem),
        .last_step_o (div_last)
    );

    assign done = done_q;
    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: tb/tb_iter_muldiv_hilo.sv
// Self-checking bench for iter_muldiv_hilo (XLEN=32) against a plain-arithmetic reference model.
module tb_iter_muldiv_hilo;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_src1;
    logic [31:0] req_src2;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    iter_muldiv_hilo #(
        .XLEN  (32),
        .CNT_W (6)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_src1  (req_src1),
        .req_src2  (req_src2),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .hi_o      (hi_o),
        .lo_o      (lo_o)
    );

    // Present one op for one cycle; returns at the negedge just after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic fl);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_src1  = a;
        req_src2  = b;
        flush     = fl;
        @(negedge clk);
        req_valid = 1'b0;
        flush     = 1'b0;
    endtask

    function automatic void mul_model(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] hi, output logic [31:0] lo);
        logic [63:0] p;
        if (sgn) p = longint'($signed(a)) * longint'($signed(b));
        else     p = {32'b0, a} * {32'b0, b};
        hi = p[63:32];
        lo = p[31:0];
    endfunction

    function automatic void div_model(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] q, output logic [31:0] r);
        longint sa, sb, lq, lr;
        if (b == 32'd0) begin
            q = '1;
            r = a;
        end else begin
            if (sgn) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = {32'b0, a};
                sb = {32'b0, b};
            end
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[31:0];
            r  = lr[31:0];
        end
    endfunction

    // Runs a divide to completion, checking latency, req_ready and the result.
    task automatic run_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input string name);
        logic [31:0] eq, er;
        int          k;
        bit          got, ready_bad;
        div_model(op == 3'd2, a, b, eq, er);
        issue(op, a, b, 1'b0);
        k = 1;
        got = 0;
        ready_bad = 0;
        while (k <= 40 && !got) begin
            if (done === 1'b1) got = 1;
            else begin
                if (req_ready !== 1'b0) ready_bad = 1;
                @(negedge clk);
                k++;
            end
        end
        checks++;
        if (!got || k != 34) begin
            errors++;
            $display("FAIL %s latency: got done at cycle %0d (seen=%0d), required 34", name, k, got);
        end
        checks++;
        if (ready_bad) begin
            errors++;
            $display("FAIL %s ready: req_ready went high mid-divide, required 0", name);
        end
        checks++;
        if (lo_o !== eq || hi_o !== er) begin
            errors++;
            $display("FAIL %s result: HI=%h LO=%h, required HI=%h LO=%h", name, hi_o, lo_o, er, eq);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req_valid = 1'b0;
        req_op = 3'd0;
        req_src1 = '0;
        req_src2 = '0;
        flush = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (hi_o !== 0 || lo_o !== 0 || busy !== 0 || done !== 0 || req_ready !== 1) begin
            errors++;
            $display("FAIL reset: HI=%h LO=%h busy=%b done=%b ready=%b, required 0/0/0/0/1",
                     hi_o, lo_o, busy, done, req_ready);
        end
    endtask

    task automatic test_mult;
        logic [31:0] a, b, eh, el;
        issue(3'd0, 32'hFFFF_FFFF, 32'h2, 1'b0);
        checks++;
        if (hi_o !== 32'hFFFF_FFFF || lo_o !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL mult_dir: HI=%h LO=%h, required ffffffff fffffffe", hi_o, lo_o);
        end
        issue(3'd1, 32'hFFFF_FFFF, 32'h2, 1'b0);
        checks++;
        if (hi_o !== 32'h1 || lo_o !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL multu_dir: HI=%h LO=%h, required 00000001 fffffffe", hi_o, lo_o);
        end
        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            b = $urandom;
            mul_model(i[0] == 1'b0, a, b, eh, el);
            issue(i[0] ? 3'd1 : 3'd0, a, b, 1'b0);
            checks++;
            if (hi_o !== eh || lo_o !== el) begin
                errors++;
                $display("FAIL mult_rand op=%0d a=%h b=%h: HI=%h LO=%h, required HI=%h LO=%h",
                         i[0], a, b, hi_o, lo_o, eh, el);
            end
        end
    endtask

    task automatic test_div;
        logic [31:0] a, b;
        run_div(3'd2, 32'hFFFF_FFF9, 32'h2, "div_m7_2");
        run_div(3'd3, 32'd100, 32'd0, "divu_by0");
        run_div(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_div(3'd2, 32'hFFFF_FFF6, 32'd0, "div_neg_by0");
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = (i == 5) ? 32'd0 : ($urandom_range(0, 1) != 0 ? $urandom : $urandom_range(1, 300));
            if ($urandom_range(0, 1) != 0) b = -b;
            run_div(i[0] ? 3'd3 : 3'd2, a, b, "div_rand");
        end
    endtask

    task automatic test_flush;
        bit saw_done;
        issue(3'd4, 32'h5, 32'h0, 1'b0);
        issue(3'd5, 32'h5, 32'h0, 1'b0);
        issue(3'd3, 32'd9, 32'd4, 1'b0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready: ready=%b busy=%b, required 1/0", req_ready, busy);
        end
        saw_done = 0;
        repeat (40) begin
            if (done === 1'b1) saw_done = 1;
            @(negedge clk);
        end
        checks++;
        if (saw_done || hi_o !== 32'h5 || lo_o !== 32'h5) begin
            errors++;
            $display("FAIL flush_abort: done_seen=%0d HI=%h LO=%h, required 0 5 5",
                     saw_done, hi_o, lo_o);
        end
        // Flush landing on the final fix-up cycle must also suppress the write.
        issue(3'd3, 32'd9, 32'd4, 1'b0);
        repeat (32) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (done !== 1'b0 || hi_o !== 32'h5 || lo_o !== 32'h5 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_fix: done=%b HI=%h LO=%h ready=%b, required 0 5 5 1",
                     done, hi_o, lo_o, req_ready);
        end
        run_div(3'd3, 32'd9, 32'd4, "divu_after_flush");
        // Reset mid-divide aborts it and clears HI/LO.
        issue(3'd3, 32'd50, 32'd7, 1'b0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || req_ready !== 1'b1 || hi_o !== 0 || lo_o !== 0) begin
            errors++;
            $display("FAIL reset_mid_div: busy=%b ready=%b HI=%h LO=%h, required 0 1 0 0",
                     busy, req_ready, hi_o, lo_o);
        end
    endtask

    task automatic test_mt;
        issue(3'd4, 32'h1234, 32'h0, 1'b0);
        issue(3'd5, 32'hABCD, 32'h0, 1'b0);
        checks++;
        if (hi_o !== 32'h1234 || lo_o !== 32'hABCD) begin
            errors++;
            $display("FAIL mthi_mtlo: HI=%h LO=%h, required 1234 abcd", hi_o, lo_o);
        end
        issue(3'd0, 32'h7, 32'h9, 1'b1);
        issue(3'd4, 32'hDEAD, 32'h0, 1'b1);
        checks++;
        if (hi_o !== 32'h1234 || lo_o !== 32'hABCD) begin
            errors++;
            $display("FAIL flushed_op: HI=%h LO=%h, required 1234 abcd", hi_o, lo_o);
        end
        issue(3'd2, 32'd20, 32'd3, 1'b1);
        checks++;
        if (busy !== 1'b0 || hi_o !== 32'h1234 || lo_o !== 32'hABCD) begin
            errors++;
            $display("FAIL flushed_div: busy=%b HI=%h LO=%h, required 0 1234 abcd",
                     busy, hi_o, lo_o);
        end
    endtask

    task automatic test_madd;
        logic [63:0] acc, p;
        logic [31:0] a, b;
        issue(3'd4, 32'h0, 32'h0, 1'b0);
        issue(3'd5, 32'hFFFF_FFFF, 32'h0, 1'b0);
        issue(3'd6, 32'h1, 32'h1, 1'b0);
`ifdef MDU_MADD_EN
        checks++;
        if (hi_o !== 32'h1 || lo_o !== 32'h0) begin
            errors++;
            $display("FAIL madd: HI=%h LO=%h, required 00000001 00000000", hi_o, lo_o);
        end
        issue(3'd7, 32'h1, 32'h1, 1'b0);
        checks++;
        if (hi_o !== 32'h0 || lo_o !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL msub: HI=%h LO=%h, required 00000000 ffffffff", hi_o, lo_o);
        end
        acc = {hi_o, lo_o};
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = $urandom;
            p = longint'($signed(a)) * longint'($signed(b));
            acc = i[0] ? acc - p : acc + p;
            issue(i[0] ? 3'd7 : 3'd6, a, b, 1'b0);
            checks++;
            if ({hi_o, lo_o} !== acc) begin
                errors++;
                $display("FAIL madd_rand: HI:LO=%h, required %h", {hi_o, lo_o}, acc);
            end
        end
`else
        checks++;
        if (hi_o !== 32'h0 || lo_o !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL madd_noop: HI=%h LO=%h, required 00000000 ffffffff", hi_o, lo_o);
        end
        issue(3'd7, 32'h1234, 32'h5678, 1'b0);
        checks++;
        if (hi_o !== 32'h0 || lo_o !== 32'hFFFF_FFFF || busy !== 1'b0) begin
            errors++;
            $display("FAIL msub_noop: HI=%h LO=%h busy=%b, required 0 ffffffff 0",
                     hi_o, lo_o, busy);
        end
        acc = '0;
        p = '0;
        a = '0;
        b = '0;
`endif
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_flush();
        test_mt();
        test_madd();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
